// File: rtl/dma_chunk_engine.sv
// dma_chunk_engine: splits one long MM2S read into datamover commands of at most CHUNK_BYTES,
// checks returned status tags and throttles the stream into the hash FIFO. Watchdog: DMA_CHUNK_TIMEOUT_EN.
module dma_chunk_engine #(
    parameter int DATA_W      = 32,
    parameter int CHUNK_BYTES = 4096,
    parameter int MAX_OUT     = 2,
    parameter int FIFO_AW     = 9,
    parameter int HEADROOM    = 32,
    parameter int TIMEOUT     = 65535
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              dma_enable_i,
    input  logic              dma_start_i,
    input  logic [31:0]       dma_base_addr_i,
    input  logic [25:0]       dma_bit_len_i,
    input  logic              consumer_rdy_i,
    output logic [79:0]       cmd_tdata_o,
    output logic              cmd_tvalid_o,
    input  logic              cmd_tready_i,
    input  logic [7:0]        sts_tdata_i,
    input  logic              sts_tvalid_i,
    output logic              sts_tready_o,
    input  logic [DATA_W-1:0] s_tdata_i,
    input  logic              s_tvalid_i,
    input  logic              s_tlast_i,
    output logic              s_tready_o,
    output logic              fifo_wr_en_o,
    output logic [DATA_W-1:0] fifo_wr_data_o,
    input  logic [FIFO_AW-1:0] fifo_wr_count_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [2:0]        err_code_o,
    output logic [7:0]        dbg_state_o
);
    // All three channels use AXI-Stream rules: a transfer happens on a rising clock edge where
    // tvalid and tready are both 1; the source holds its payload stable until that edge.

    if (CHUNK_BYTES < 1 || CHUNK_BYTES > (1 << 22) || MAX_OUT < 1 || MAX_OUT > 4 || TIMEOUT < 1) begin : g_bad_params
        $error("dma_chunk_engine: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    localparam logic [23:0]      CHUNK   = 24'(CHUNK_BYTES);
    localparam logic [2:0]       OUT_MAX = 3'(MAX_OUT);
    localparam logic [FIFO_AW:0] LIMIT   = (FIFO_AW + 1)'((1 << FIFO_AW) - HEADROOM);

    state_t            state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [23:0]       rem_q, rem_d;
    logic [2:0]        out_q, out_d;
    logic [3:0]        issue_tag_q, issue_tag_d;
    logic [3:0]        exp_tag_q, exp_tag_d;
    logic [1:0]        chunk_q, chunk_d;
    logic              last_q, last_d;
    logic              err_q, err_d;
    logic [2:0]        code_q, code_d;
    logic [4:0]        quiet_q, quiet_d;
    logic              start_q, start_edge_q;
    logic              sts_rdy_q, tready_q, wr_en_q, done_q, busy_q;
    logic [DATA_W-1:0] wr_data_q;

    logic        active, cmd_valid, cmd_hs, sts_acc, sts_chk, sts_dec, sts_bad, beat, eof, abort_req;
    logic [23:0] btt_w, bytes;
    logic [2:0]  sts_code;

`ifdef DMA_CHUNK_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    assign active    = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign cmd_valid = (state_q == S_ISSUE);
    assign cmd_hs    = cmd_valid && cmd_tready_i;
    assign sts_acc   = sts_tvalid_i && sts_rdy_q;
    assign sts_chk   = sts_acc && (state_q != S_IDLE);
    assign sts_dec   = sts_chk && (out_q != 3'd0);
    assign beat      = s_tvalid_i && tready_q;
    assign btt_w     = (rem_q > CHUNK) ? CHUNK : rem_q;
    assign eof       = (btt_w == rem_q);
    assign bytes     = {1'b0, dma_bit_len_i[25:3]} + {23'd0, |dma_bit_len_i[2:0]};
    // A status with nothing outstanding can only be a stray tag, so it is reported as a mismatch.
    assign sts_bad   = !sts_tdata_i[7] || (|sts_tdata_i[6:4]) || (sts_tdata_i[3:0] != exp_tag_q) || (out_q == 3'd0);

    always_comb begin
        sts_code = 3'd4;
        if (sts_tdata_i[6])      sts_code = 3'd1;
        else if (sts_tdata_i[5]) sts_code = 3'd2;
        else if (sts_tdata_i[4]) sts_code = 3'd3;
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        issue_tag_d = issue_tag_q;
        exp_tag_d   = exp_tag_q;
        chunk_d     = chunk_q;
        last_d      = last_q;
        err_d       = err_q;
        code_d      = code_q;
        quiet_d     = '0;
        abort_req   = 1'b0;
        out_d       = out_q + {2'b0, cmd_hs} - {2'b0, sts_dec};
`ifdef DMA_CHUNK_TIMEOUT_EN
        wd_d        = '0;
`endif
        if (sts_chk) begin
            exp_tag_d = exp_tag_q + 4'd1;
            if (sts_bad) begin
                abort_req = 1'b1;
                if (!err_q) begin
                    err_d  = 1'b1;
                    code_d = sts_code;
                end
            end
        end
        if (beat && s_tlast_i && state_q != S_IDLE) last_d = 1'b1;
        if (active && !dma_enable_i) begin
            abort_req = 1'b1;
            if (!err_d) begin
                err_d  = 1'b1;
                code_d = 3'd5;
            end
        end
`ifdef DMA_CHUNK_TIMEOUT_EN
        if (active) begin
            if (beat || cmd_hs || sts_acc) begin
                wd_d = '0;
            end else if (wd_q == WD_MAX) begin
                abort_req = 1'b1;
                if (!err_d) begin
                    err_d  = 1'b1;
                    code_d = 3'd6;
                end
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
        case (state_q)
            S_IDLE: begin
                // A latched error never blocks a restart: the accepted start is what clears it.
                if (start_edge_q && dma_enable_i && consumer_rdy_i) begin
                    addr_d    = dma_base_addr_i;
                    rem_d     = bytes;
                    exp_tag_d = issue_tag_q;
                    chunk_d   = '0;
                    last_d    = 1'b0;
                    err_d     = 1'b0;
                    code_d    = 3'd0;
                    state_d   = (bytes == 24'd0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_hs) begin
                    addr_d      = addr_q + {8'd0, btt_w};
                    rem_d       = rem_q - btt_w;
                    issue_tag_d = issue_tag_q + 4'd1;
                    chunk_d     = chunk_q + 2'd1;
                    if (eof)                   state_d = S_DRAIN;
                    else if (out_d >= OUT_MAX) state_d = S_WAIT;
                end
            end
            S_WAIT:  if (out_q < OUT_MAX) state_d = S_ISSUE;
            S_DRAIN: if (out_q == 3'd0 && last_q) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_ABORT: begin
                quiet_d = s_tvalid_i ? 5'd0 : ((quiet_q == 5'd16) ? quiet_q : quiet_q + 5'd1);
                if (out_q == 3'd0 && quiet_q == 5'd16) state_d = S_IDLE;
`ifdef DMA_CHUNK_TIMEOUT_EN
                if (wd_q == WD_MAX) begin
                    state_d = S_IDLE;
                    out_d   = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        if (active && abort_req) begin
            state_d = S_ABORT;
`ifdef DMA_CHUNK_TIMEOUT_EN
            wd_d = '0;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            out_q        <= '0;
            issue_tag_q  <= '0;
            exp_tag_q    <= '0;
            chunk_q      <= '0;
            last_q       <= 1'b0;
            err_q        <= 1'b0;
            code_q       <= '0;
            quiet_q      <= '0;
            start_q      <= 1'b0;
            start_edge_q <= 1'b0;
            sts_rdy_q    <= 1'b0;
            tready_q     <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            out_q        <= out_d;
            issue_tag_q  <= issue_tag_d;
            exp_tag_q    <= exp_tag_d;
            chunk_q      <= chunk_d;
            last_q       <= last_d;
            err_q        <= err_d;
            code_q       <= code_d;
            quiet_q      <= quiet_d;
            start_q      <= dma_start_i;
            start_edge_q <= dma_start_i && !start_q;
            sts_rdy_q    <= 1'b1;
            // In ABORT the stream is sunk unconditionally so the datamover can finish its bursts.
            tready_q     <= (state_q == S_ABORT) || (active && ({1'b0, fifo_wr_count_i} < LIMIT));
            wr_en_q      <= beat && active;
            if (beat) wr_data_q <= s_tdata_i;
            done_q       <= (state_q == S_DONE);
            busy_q       <= (state_q != S_IDLE);
        end
    end

`ifdef DMA_CHUNK_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) wd_q <= '0;
        else         wd_q <= wd_d;
    end
`endif

    assign cmd_tvalid_o   = cmd_valid;
    assign cmd_tdata_o    = cmd_valid ? {4'b0001, 4'b0000, 4'b0000, issue_tag_q, addr_q,
                                         1'b1, eof, 6'b000000, 1'b1, btt_w[22:0]} : 80'd0;
    assign sts_tready_o   = sts_rdy_q;
    assign s_tready_o     = tready_q;
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_wr_data_o = wr_data_q;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign err_code_o     = code_q;
    assign dbg_state_o    = {out_q, state_q, chunk_q};

endmodule

// File: tb/tb_dma_chunk_engine.sv
// Directed bench for dma_chunk_engine: chunking, outstanding limit, status errors, abort,
// throttle and zero-length starts (watchdog case only when DMA_CHUNK_TIMEOUT_EN is defined).
module tb_dma_chunk_engine;
    localparam int DATA_W = 64;

    logic              clk = 1'b0;
    logic              rstn;
    logic              dma_enable, dma_start, consumer_rdy;
    logic [31:0]       dma_base_addr;
    logic [25:0]       dma_bit_len;
    logic [79:0]       cmd_tdata;
    logic              cmd_tvalid, cmd_tready;
    logic [7:0]        sts_tdata;
    logic              sts_tvalid, sts_tready;
    logic [DATA_W-1:0] s_tdata;
    logic              s_tvalid, s_tlast, s_tready;
    logic              fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic [8:0]        fifo_wr_count;
    logic              busy, done, err;
    logic [2:0]        err_code;
    logic [7:0]        dbg_state;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    logic [DATA_W-1:0] last_wr = '0;
    logic [79:0] act_q[$];
    logic [79:0] exp_q[$];

    dma_chunk_engine #(
        .DATA_W(DATA_W), .CHUNK_BYTES(4096), .MAX_OUT(2), .FIFO_AW(9), .HEADROOM(32), .TIMEOUT(200)
    ) dut (
        .clk_i(clk), .rstn_i(rstn), .dma_enable_i(dma_enable), .dma_start_i(dma_start),
        .dma_base_addr_i(dma_base_addr), .dma_bit_len_i(dma_bit_len), .consumer_rdy_i(consumer_rdy),
        .cmd_tdata_o(cmd_tdata), .cmd_tvalid_o(cmd_tvalid), .cmd_tready_i(cmd_tready),
        .sts_tdata_i(sts_tdata), .sts_tvalid_i(sts_tvalid), .sts_tready_o(sts_tready),
        .s_tdata_i(s_tdata), .s_tvalid_i(s_tvalid), .s_tlast_i(s_tlast), .s_tready_o(s_tready),
        .fifo_wr_en_o(fifo_wr_en), .fifo_wr_data_o(fifo_wr_data), .fifo_wr_count_i(fifo_wr_count),
        .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(err_code), .dbg_state_o(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

    // monitors: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (fifo_wr_en) begin
            wr_cnt++;
            last_wr = fifo_wr_data;
        end
        if (done) done_cnt++;
        if (cmd_tvalid && cmd_tready) act_q.push_back(cmd_tdata);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] mk_cmd(input logic [3:0] tag, input logic [31:0] addr,
                                           input logic eof, input logic [22:0] btt);
        return {4'h1, 4'h0, 4'h0, tag, addr, 1'b1, eof, 6'h00, 1'b1, btt};
    endfunction

    // driver tasks
    task automatic do_reset();
        rstn = 1'b0;
        dma_start = 1'b0; cmd_tready = 1'b0; sts_tvalid = 1'b0; sts_tdata = '0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; fifo_wr_count = '0;
        dma_enable = 1'b1; consumer_rdy = 1'b1;
        repeat (3) tick();
        rstn = 1'b1;
        tick();
        act_q.delete();
        exp_q.delete();
    endtask

    task automatic do_start(input logic [25:0] bits, input logic [31:0] base);
        dma_bit_len = bits;
        dma_base_addr = base;
        dma_start = 1'b1;
        tick();
        dma_start = 1'b0;
    endtask

    task automatic send_beat(input logic [DATA_W-1:0] d, input logic last);
        int n = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        while (!s_tready && n < 200) begin
            tick();
            n++;
        end
        chk("s_tready_wait", s_tready, 1);
        tick();
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_sts(input logic [7:0] d);
        sts_tvalid = 1'b1; sts_tdata = d;
        tick();
        sts_tvalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk(tag, busy, 0);
    endtask

    task automatic compare_cmds(input string tag);
        chk({tag, "_count"}, act_q.size(), exp_q.size());
        while (exp_q.size() > 0 && act_q.size() > 0) chk(tag, act_q.pop_front(), exp_q.pop_front());
    endtask

    initial begin
        int d0, w0;
        dma_bit_len = '0; dma_base_addr = '0;
        rstn = 1'b0;
        dma_start = 1'b0; cmd_tready = 1'b0; sts_tvalid = 1'b0; sts_tdata = '0;
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; fifo_wr_count = '0;
        dma_enable = 1'b1; consumer_rdy = 1'b1;
        tick(); tick();
        chk("rst_cmd_tvalid", cmd_tvalid, 0);
        chk("rst_cmd_tdata", cmd_tdata, 0);
        chk("rst_sts_tready", sts_tready, 0);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_dbg", dbg_state, 0);
        rstn = 1'b1;
        tick();
        chk("sts_tready_up", sts_tready, 1);

        // single 1000-byte chunk, 125 beats
        do_reset();
        cmd_tready = 1'b1;
        do_start(26'd8000, 32'h1000_0000);
        chk("t1_no_cmd_yet", cmd_tvalid, 0);
        tick();
        chk("t1_cmd_tvalid", cmd_tvalid, 1);
        chk("t1_cmd_tdata", cmd_tdata, mk_cmd(4'd0, 32'h1000_0000, 1'b1, 23'd1000));
        exp_q.push_back(mk_cmd(4'd0, 32'h1000_0000, 1'b1, 23'd1000));
        tick();
        chk("t1_dbg_drain", dbg_state, 8'h2D);
        wr_cnt = 0;
        d0 = done_cnt;
        send_beat(64'd0, 1'b0);
        chk("t1_first_wr_en", fifo_wr_en, 1);
        chk("t1_first_wr_data", fifo_wr_data, 0);
        for (int i = 1; i < 125; i++) send_beat(64'(i), i == 124);
        send_sts(8'h80);
        chk("t1_done_n0", done, 0);
        tick();
        chk("t1_done_n1", done, 0);
        tick();
        chk("t1_done_n2", done, 1);
        chk("t1_busy_n2", busy, 1);
        tick();
        chk("t1_busy_n3", busy, 0);
        chk("t1_wr_cnt", wr_cnt, 125);
        chk("t1_last_wr", last_wr, 124);
        chk("t1_done_cnt", done_cnt - d0, 1);
        chk("t1_err", err, 0);
        compare_cmds("t1_cmd");

        // 10241 bytes: three chunks, third held by the outstanding limit
        do_reset();
        cmd_tready = 1'b1;
        do_start(26'd81928, 32'h2000_0000);
        exp_q.push_back(mk_cmd(4'd0, 32'h2000_0000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'd1, 32'h2000_1000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'd2, 32'h2000_2000, 1'b1, 23'd2049));
        repeat (8) tick();
        chk("t2_held_tvalid", cmd_tvalid, 0);
        chk("t2_held_count", act_q.size(), 2);
        chk("t2_dbg_wait", dbg_state, 8'h4A);
        d0 = done_cnt;
        wr_cnt = 0;
        send_sts(8'h80);
        repeat (3) tick();
        chk("t2_third_issued", act_q.size(), 3);
        send_beat(64'hA, 1'b0);
        send_beat(64'hB, 1'b0);
        send_beat(64'hC, 1'b1);
        send_sts(8'h81);
        send_sts(8'h82);
        wait_idle("t2_idle", 20);
        chk("t2_done_cnt", done_cnt - d0, 1);
        chk("t2_wr_cnt", wr_cnt, 3);
        chk("t2_err", err, 0);
        compare_cmds("t2_cmd");

        // SLVERR on the second chunk
        do_reset();
        cmd_tready = 1'b1;
        do_start(26'd81928, 32'h2000_0000);
        exp_q.push_back(mk_cmd(4'd0, 32'h2000_0000, 1'b0, 23'd4096));
        exp_q.push_back(mk_cmd(4'd1, 32'h2000_1000, 1'b0, 23'd4096));
        repeat (3) tick();
        cmd_tready = 1'b0;
        d0 = done_cnt;
        send_sts(8'h80);
        tick();
        chk("t3_third_pending", cmd_tvalid, 1);
        send_sts(8'h41);
        chk("t3_err", err, 1);
        chk("t3_code", err_code, 1);
        chk("t3_tvalid_drop", cmd_tvalid, 0);
        chk("t3_dbg_abort", dbg_state, 8'h16);
        cmd_tready = 1'b1;
        tick();
        chk("t3_abort_tready", s_tready, 1);
        w0 = wr_cnt;
        send_beat(64'hDEAD, 1'b1);
        chk("t3_no_fifo_wr", fifo_wr_en, 0);
        wait_idle("t3_idle", 60);
        chk("t3_wr_cnt", wr_cnt - w0, 0);
        chk("t3_no_done", done_cnt - d0, 0);
        chk("t3_err_sticky", err, 1);
        compare_cmds("t3_cmd");

        // disable while a command is pending; the start also clears the previous error
        cmd_tready = 1'b0;
        d0 = done_cnt;
        do_start(26'd800, 32'h3000_0000);
        tick();
        chk("t4_tvalid", cmd_tvalid, 1);
        chk("t4_err_cleared", err, 0);
        chk("t4_code_cleared", err_code, 0);
        dma_enable = 1'b0;
        tick();
        chk("t4_tvalid_drop", cmd_tvalid, 0);
        chk("t4_err", err, 1);
        chk("t4_code", err_code, 5);
        repeat (16) tick();
        chk("t4_busy_quiet", busy, 1);
        repeat (2) tick();
        chk("t4_busy_off", busy, 0);
        chk("t4_no_done", done_cnt - d0, 0);
        dma_enable = 1'b1;

        // FIFO headroom throttle
        do_reset();
        do_start(26'd81928, 32'h0);
        tick(); tick();
        chk("t5_tready_open", s_tready, 1);
        fifo_wr_count = 9'd480;
        tick();
        chk("t5_tready_480", s_tready, 0);
        fifo_wr_count = 9'd479;
        tick();
        chk("t5_tready_479", s_tready, 1);
        fifo_wr_count = 9'd511;
        tick();
        chk("t5_tready_511", s_tready, 0);

        // start gating, zero length and a sub-byte length
        do_reset();
        consumer_rdy = 1'b0;
        do_start(26'd8000, 32'h0);
        repeat (3) tick();
        chk("t6_not_ready_busy", busy, 0);
        chk("t6_not_ready_cmd", cmd_tvalid, 0);
        consumer_rdy = 1'b1;
        d0 = done_cnt;
        do_start(26'd0, 32'h0);
        tick();
        chk("t6_zero_done_n1", done, 0);
        tick();
        chk("t6_zero_done_n2", done, 1);
        tick();
        chk("t6_zero_done_once", done_cnt - d0, 1);
        chk("t6_zero_no_cmd", act_q.size(), 0);
        do_start(26'd9, 32'h0000_0044);
        tick();
        chk("t6_9bits_cmd", cmd_tdata, mk_cmd(4'd0, 32'h0000_0044, 1'b1, 23'd2));

`ifdef DMA_CHUNK_TIMEOUT_EN
        // stalled stream trips the watchdog
        do_reset();
        cmd_tready = 1'b1;
        do_start(26'd8000, 32'h5000_0000);
        tick(); tick();
        begin
            int n = 0;
            while (!err && n < 400) begin
                tick();
                n++;
            end
        end
        chk("t7_wd_err", err, 1);
        chk("t7_wd_code", err_code, 6);
        wait_idle("t7_wd_idle", 600);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
